// File: rtl/brick_map_tracker.sv
// Live brick bitmap for a 4x8 breakout grid: level loading, LFSR-randomised
// layouts, hit removal with acknowledge pulses and a remaining-brick count.
module brick_map_tracker #(
    parameter logic [31:0] L1_MAP    = 32'h00FF_FF00,
    parameter logic [31:0] L2_MAP    = 32'hA5A5_5A5A,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [1:0]  lvl,
    input  logic        preState,
    input  logic        random,
    input  logic        brickHit,
    input  logic [1:0]  hitRow,
    input  logic [2:0]  hitCol,
    output logic [31:0] brickMap,
    output logic [5:0]  bricksLeft,
    output logic        hitAck,
    output logic        noBrick
);

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [31:0] rnd_pattern;
    logic [31:0] load_map;
    logic [4:0]  hit_idx;

    function automatic logic [5:0] popcount(input logic [31:0] m);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, m[i]};
        end
        return cnt;
    endfunction

    always_comb begin
        lfsr_next   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        rnd_pattern = {lfsr, lfsr ^ {lfsr[7:0], lfsr[15:8]}};
        // An empty random layout would end the level instantly; fall back to level 1.
        if (rnd_pattern == 32'd0) begin
            rnd_pattern = L1_MAP;
        end
        hit_idx = {hitRow, hitCol};
        case (lvl)
            2'd0:    load_map = 32'd0;
            2'd1:    load_map = L1_MAP;
            2'd2:    load_map = L2_MAP;
            default: load_map = random ? rnd_pattern : brickMap;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            lfsr       <= LFSR_SEED;
            brickMap   <= 32'd0;
            bricksLeft <= 6'd0;
            hitAck     <= 1'b0;
            noBrick    <= 1'b0;
        end else begin
            lfsr    <= lfsr_next;
            hitAck  <= 1'b0;
            noBrick <= 1'b0;
            if (preState) begin
                // Loading always wins over a coincident hit.
                brickMap   <= load_map;
                bricksLeft <= popcount(load_map);
            end else if (brickHit && brickMap[hit_idx]) begin
                brickMap[hit_idx] <= 1'b0;
                bricksLeft        <= bricksLeft - 6'd1;
                hitAck            <= 1'b1;
                noBrick           <= (bricksLeft == 6'd1);
            end
        end
    end

endmodule

// File: doc/brick_map_tracker.md
BRICK_MAP_TRACKER -- requirements
Module: brick_map_tracker

Interface
REQ-001 Parameter L1_MAP, default 32'h00FF_FF00, SHALL be the level-1 brick pattern; bit index = row*8+col.
REQ-002 Parameter L2_MAP, default 32'hA5A5_5A5A, SHALL be the level-2 brick pattern.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, SHALL be the LFSR reset value and SHALL be nonzero.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 Port clk, input, 1, SHALL be the system clock; all state updates on its rising edge.
REQ-006 Port resetN, input, 1, SHALL be the synchronous active-low reset.
REQ-007 Port lvl, input, 2, SHALL be the current level from the game state machine: 0 none, 1, 2, 3 random.
REQ-008 Port preState, input, 1, SHALL mean pre-game or menu; high = load phase, low = play phase.
REQ-009 Port random, input, 1, SHALL mean randomize phase active.
REQ-010 Port brickHit, input, 1, SHALL be a single-cycle collision request from the ball logic.
REQ-011 Port hitRow, input, 2, and hitCol, input, 3, SHALL address the hit brick in a 4x8 grid.
REQ-012 Port brickMap, output, 32, SHALL be the registered live brick bitmap for the drawing logic.
REQ-013 Port bricksLeft, output, 6, SHALL be the registered count of set bits in brickMap (0..32).
REQ-014 Port hitAck, output, 1, SHALL pulse for one cycle when a brick is actually removed.
REQ-015 Port noBrick, output, 1, SHALL pulse for one cycle when the last brick is removed.

Function
REQ-016 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle, independent of the other inputs.
REQ-017 The random pattern SHALL be {lfsr, lfsr ^ {lfsr[7:0], lfsr[15:8]}}; if this pattern is zero, L1_MAP SHALL be used instead.
REQ-018 Load phase (preState=1), every cycle, brickMap next value:
- lvl=0 -> 0
- lvl=1 -> L1_MAP
- lvl=2 -> L2_MAP
- lvl=3 with random=1 -> random pattern
- lvl=3 with random=0 -> hold (frozen layout and remaining bricks are kept across a life loss)
REQ-019 On every load-phase edge, bricksLeft SHALL take the popcount of the new brickMap value, registered in the same edge.
REQ-020 In the load phase, brickHit SHALL be ignored: hitAck=0, noBrick=0.
REQ-021 Play phase (preState=0), brickHit=1 with bit row*8+col set:
- that bit SHALL clear at the next edge
- bricksLeft SHALL decrement by 1 at the same edge
- hitAck SHALL be 1 for exactly that following cycle
REQ-022 In the play phase, brickHit=1 on an already-clear bit SHALL change nothing, and hitAck SHALL stay 0.
REQ-023 noBrick SHALL assert in the cycle after the hit that takes bricksLeft from 1 to 0, together with hitAck, for one cycle only.
REQ-024 In the play phase, the map SHALL change only by hits, so bricksLeft never underflows; with bricksLeft=0, a hit SHALL produce no output pulse.
REQ-025 brickHit held high for several cycles on one address SHALL remove one brick and produce one hitAck pulse.
REQ-026 A preState 0->1 edge with a simultaneous brickHit: the load SHALL win, and the hit SHALL be discarded.
REQ-027 All outputs SHALL be registers, with no combinational path from any input to any output.

Reset
REQ-028 With resetN=0 at a clock edge:
- brickMap=0, bricksLeft=0, hitAck=0, noBrick=0
- lfsr=LFSR_SEED
REQ-029 Reset asserted mid-play SHALL discard any pending hit, and no pulse SHALL follow the reset release.

Verification
REQ-030 Reset, then preState=1, lvl=1 for one cycle -> brickMap=32'h00FF_FF00, bricksLeft=16 at the next edge.
REQ-031 lvl=2 loaded, then preState=0, brickHit at row0 col1 (bit1 set) -> bit1 clears, bricksLeft 16->15, hitAck=1 for one cycle.
REQ-032 Repeat the same hit with brickHit high for 3 cycles -> no change, hitAck=0 throughout.
REQ-033 Load the map with a single bit set via a level-1 run that has 15 bricks cleared, then hit the last brick -> bricksLeft=0, hitAck=1 and noBrick=1 in the same single cycle; a further hit produces no pulse.
REQ-034 lvl=3, random=1 for N cycles, then random=0 -> brickMap equals the reference-model LFSR pattern of the last random cycle and stays held; bricksLeft equals its popcount.
REQ-035 brickHit asserted in the same cycle as preState 0->1 with lvl=1 -> brickMap=L1_MAP, bricksLeft=16, no hitAck.
